// File: rtl/jump_step_sequencer.sv
// ---------------------------------------------------------------------------
// jump_step_sequencer
//
// Control-step generator for the Mini-SRC datapath. It runs the instruction
// fetch (T0..T2, with MEM_WAIT extra read-wait cycles in T1) and then executes
// the jump class:
//   jr  : PC <- R[ra]
//   jal : R15 <- PC (already incremented), then PC <- R[ra]
// Any other opcode seen in T3 raises a one-cycle illegal pulse and the
// instruction is dropped.
//
// Parameters
//   OPW       opcode width
//   OP_JR     jr opcode
//   OP_JAL    jal opcode
//   MEM_WAIT  extra T1 cycles holding Read/MDRin (0..7)
//
// Ports
//   clock     rising-edge clock
//   clear     asynchronous active-low reset (state -> IDLE, outputs 0)
//   run       start/continue sequencing; looked at only in IDLE and at retire
//   stall     freeze state and wait count; all controls forced 0 that cycle
//   ir_op     opcode field of IR, used in T3
//   PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin   datapath controls
//   Gra, Rout, Rin, LinkSel   register-select controls (LinkSel steers Rin to R15)
//   step      encoded state: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5
//   busy      1 in every state except IDLE
//   done      one-cycle pulse in the cycle that retires a jr/jal
//   illegal   one-cycle pulse in T3 for an opcode that is neither jr nor jal
// ---------------------------------------------------------------------------
module jump_step_sequencer #(
  parameter int              OPW      = 5,
  parameter logic [OPW-1:0]  OP_JR    = OPW'(5'b10100),
  parameter logic [OPW-1:0]  OP_JAL   = OPW'(5'b10011),
  parameter int              MEM_WAIT = 0
) (
  input  logic           clock,
  input  logic           clear,
  input  logic           run,
  input  logic           stall,
  input  logic [OPW-1:0] ir_op,
  output logic           PCout,
  output logic           MARin,
  output logic           IncPC,
  output logic           PCin,
  output logic           Read,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Gra,
  output logic           Rout,
  output logic           Rin,
  output logic           LinkSel,
  output logic [2:0]     step,
  output logic           busy,
  output logic           done,
  output logic           illegal
);

  // The wait counter is only 3 bits wide.
  if (MEM_WAIT < 0 || MEM_WAIT > 7) begin : g_mem_wait_range
    $error("jump_step_sequencer: MEM_WAIT must be in 0..7");
  end

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T0   = 3'd1;
  localparam logic [2:0] ST_T1   = 3'd2;
  localparam logic [2:0] ST_T2   = 3'd3;
  localparam logic [2:0] ST_T3   = 3'd4;
  localparam logic [2:0] ST_T4   = 3'd5;
  localparam int         NUM_ST  = 6;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  logic [2:0] state_reg, state_next;
  logic [2:0] wait_reg, wait_next;
  logic [2:0] retire_state;

  logic       is_jr, is_jal;
  logic       ctl_en;
  logic       jump_exec;
  logic       link_exec;

  // One-hot view of the encoded state; every control is an OR of these bits,
  // so outputs only change when state_reg (or stall) changes.
  logic [NUM_ST-1:0] in_state;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ST; gi++) begin : g_state_decode
      assign in_state[gi] = (state_reg == 3'(gi));
    end
  endgenerate

  assign is_jr  = (ir_op == OP_JR);
  assign is_jal = (ir_op == OP_JAL);

  // Where to go after the last step of an instruction: straight into the next
  // fetch (no bubble) or back to IDLE when run has dropped.
  assign retire_state = run ? ST_T0 : ST_IDLE;

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    if (!stall) begin
      case (state_reg)
        ST_IDLE: if (run) state_next = ST_T0;
        ST_T0:   state_next = ST_T1;
        ST_T1: begin
          if (wait_reg == WAIT_LAST) begin
            state_next = ST_T2;
            wait_next  = 3'd0;
          end else begin
            wait_next  = wait_reg + 3'd1;
          end
        end
        ST_T2:   state_next = ST_T3;
        ST_T3:   state_next = is_jal ? ST_T4 : retire_state;
        ST_T4:   state_next = retire_state;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg <= ST_IDLE;
      wait_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

  // Controls are Moore decodes gated by ~stall, so a stalled cycle drives
  // nothing onto the bus and writes nothing.
  assign ctl_en    = ~stall;
  assign jump_exec = (in_state[ST_T3] & is_jr) | in_state[ST_T4];
  assign link_exec = in_state[ST_T3] & is_jal;

  // PCout appears in T0 and jal-T3, Rout in the jump step, MDRout in T2:
  // disjoint states, so the bus always has at most one driver.
  assign PCout   = ctl_en & (in_state[ST_T0] | link_exec);
  assign MARin   = ctl_en & in_state[ST_T0];
  assign IncPC   = ctl_en & in_state[ST_T0];
  assign PCin    = ctl_en & (in_state[ST_T0] | jump_exec);
  assign Read    = ctl_en & in_state[ST_T1];
  assign MDRin   = ctl_en & in_state[ST_T1];
  assign MDRout  = ctl_en & in_state[ST_T2];
  assign IRin    = ctl_en & in_state[ST_T2];
  assign Gra     = ctl_en & jump_exec;
  assign Rout    = ctl_en & jump_exec;
  assign Rin     = ctl_en & link_exec;
  assign LinkSel = ctl_en & link_exec;

  assign done    = ctl_en & jump_exec;
  assign illegal = ctl_en & in_state[ST_T3] & ~is_jr & ~is_jal;

  assign step    = state_reg;
  assign busy    = ~in_state[ST_IDLE];

endmodule

// File: tb/tb_jump_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jump_step_sequencer
//
// Drives jump_step_sequencer (MEM_WAIT=3) attached to a small behavioural
// Mini-SRC datapath (PC, MAR, MDR, IR, 16 registers, 64-word memory).
// The reference model describes each instruction as the list of steps it must
// walk through (T0, MEM_WAIT+1 x T1, T2, T3, [T4]); a stalled cycle repeats
// the current list entry with all controls at 0. Architectural results
// (PC, R15) are computed from the jr/jal rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_jump_step_sequencer;

  localparam int         MW     = 3;
  localparam logic [4:0] OP_JR  = 5'b10100;
  localparam logic [4:0] OP_JAL = 5'b10011;

  logic       clock = 1'b0;
  logic       clear, run, stall;
  logic [4:0] ir_op;
  logic       PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic       Gra, Rout, Rin, LinkSel;
  logic [2:0] step;
  logic       busy, done, illegal;

  jump_step_sequencer #(
    .OPW(5), .OP_JR(OP_JR), .OP_JAL(OP_JAL), .MEM_WAIT(MW)
  ) dut (
    .clock(clock), .clear(clear), .run(run), .stall(stall), .ir_op(ir_op),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Gra(Gra), .Rout(Rout), .Rin(Rin), .LinkSel(LinkSel),
    .step(step), .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural datapath ----------------
  logic [31:0] mem [64];
  logic [31:0] regs [16];
  logic [31:0] init_regs [16];
  logic [31:0] pc, mar, mdr, ir, bus, load_pc;
  logic        dp_load;
  logic [3:0]  ra;

  assign ra    = ir[26:23];
  assign ir_op = ir[31:27];

  always_comb begin
    if (PCout)       bus = pc;
    else if (Rout)   bus = regs[ra];
    else if (MDRout) bus = mdr;
    else             bus = 32'd0;
  end

  always @(posedge clock) begin
    if (dp_load) begin
      pc  <= load_pc;
      mar <= 32'd0;
      mdr <= 32'd0;
      ir  <= 32'd0;
      for (int i = 0; i < 16; i++) regs[i] <= init_regs[i];
    end else begin
      if (MARin)         mar <= bus;
      if (PCin)          pc  <= IncPC ? pc + 32'd1 : bus;
      if (Read && MDRin) mdr <= mem[mar[5:0]];
      if (IRin)          ir  <= bus;
      if (Rin)           regs[LinkSel ? 4'd15 : ra] <= bus;
    end
  end

  // ---------------- reference model ----------------
  int          m_steps [$];
  logic [4:0]  m_op;
  logic [3:0]  m_ra;
  logic [31:0] m_pc1;
  logic [31:0] exp_pc;
  logic [31:0] exp_regs [16];
  logic        m_retired;
  int          n_retired;

  int checks   = 0;
  int failures = 0;

  logic [17:0] act_vec, ev;
  assign act_vec = {step, busy, done, illegal,
                    PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
                    Gra, Rout, Rin, LinkSel};

  function automatic int model_front();
    return (m_steps.size() != 0) ? m_steps[0] : 0;
  endfunction

  // Expected output vector for the current model position.
  function automatic logic [17:0] exp_vec(input logic st_v);
    int         s;
    logic [11:0] c;
    logic        d, il;
    s  = model_front();
    c  = 12'd0;
    d  = 1'b0;
    il = 1'b0;
    case (s)
      1: c = 12'b1111_0000_0000;
      2: c = 12'b0000_1100_0000;
      3: c = 12'b0000_0011_0000;
      4: begin
        if (m_op == OP_JR) begin
          c = 12'b0001_0000_1100; d = 1'b1;
        end else if (m_op == OP_JAL) begin
          c = 12'b1000_0000_0011;
        end else begin
          il = 1'b1;
        end
      end
      5: begin c = 12'b0001_0000_1100; d = 1'b1; end
      default: c = 12'd0;
    endcase
    if (st_v) begin
      c = 12'd0; d = 1'b0; il = 1'b0;
    end
    return {3'(s), (s != 0), d, il, c};
  endfunction

  task automatic load_instr();
    logic [31:0] w;
    w     = mem[exp_pc[5:0]];
    m_op  = w[31:27];
    m_ra  = w[26:23];
    m_pc1 = exp_pc + 32'd1;
    m_steps.delete();
    m_steps.push_back(1);
    for (int k = 0; k <= MW; k++) m_steps.push_back(2);
    m_steps.push_back(3);
    m_steps.push_back(4);
    if (m_op == OP_JAL) m_steps.push_back(5);
  endtask

  task automatic retire();
    if (m_op == OP_JR) begin
      exp_pc = exp_regs[m_ra];
    end else if (m_op == OP_JAL) begin
      exp_regs[15] = m_pc1;
      exp_pc       = exp_regs[m_ra];
    end else begin
      exp_pc = m_pc1;
    end
    m_retired = 1'b1;
    n_retired++;
  endtask

  // Advance the model by one clock edge with the inputs that edge saw.
  task automatic model_edge(input logic st_v, input logic run_v);
    m_retired = 1'b0;
    if (st_v) return;
    if (m_steps.size() == 0) begin
      if (run_v) load_instr();
    end else begin
      void'(m_steps.pop_front());
      if (m_steps.size() == 0) begin
        retire();
        if (run_v) load_instr();
      end
    end
  endtask

  task automatic model_clear();
    int s;
    s = model_front();
    if (s > 1)  exp_pc       = m_pc1;
    if (s == 5) exp_regs[15] = m_pc1;
    m_steps.delete();
  endtask

  task automatic restart(input logic [31:0] pc0);
    @(negedge clock);
    clear   = 1'b0;
    run     = 1'b0;
    stall   = 1'b0;
    load_pc = pc0;
    dp_load = 1'b1;
    m_steps.delete();
    m_retired = 1'b0;
    @(posedge clock);
    #1 dp_load = 1'b0;
    exp_pc   = pc0;
    exp_regs = init_regs;
    @(negedge clock);
    clear = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear   = 1'b0;
    run     = 1'b1;
    stall   = 1'b0;
    load_pc = 32'd0;
    dp_load = 1'b1;
    for (int i = 0; i < 16; i++) init_regs[i] = 32'd0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (act_vec !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", act_vec, 18'd0);
    end
    $display("test_reset: step=%0d busy=%0d", step, busy);
  endtask

  task automatic test_jr();
    int done_cyc = -1, read_cnt = 0;
    for (int i = 0; i < 16; i++) init_regs[i] = 32'd50 + 32'(i);
    init_regs[6] = 32'd27;
    mem[13] = {OP_JR, 4'd6, 23'd0};
    restart(32'd13);
    for (int c = 0; c < 6 + MW; c++) begin
      @(negedge clock);
      stall = 1'b0;
      run   = (c == 0);
      #1;
      ev = exp_vec(stall);
      checks++;
      if (act_vec !== ev) begin
        failures++;
        $display("FAIL jr_vec cyc=%0d got=%b want=%b", c, act_vec, ev);
      end
      if (done && done_cyc < 0) done_cyc = c;
      if (Read && MDRin) read_cnt++;
      @(posedge clock);
      model_edge(stall, run);
    end
    checks++;
    if (pc !== 32'd27) begin
      failures++;
      $display("FAIL jr_pc got=%0d want=27", pc);
    end
    checks++;
    if (done_cyc !== 4 + MW) begin
      failures++;
      $display("FAIL jr_latency got=%0d want=%0d", done_cyc, 4 + MW);
    end
    checks++;
    if (read_cnt !== MW + 1) begin
      failures++;
      $display("FAIL jr_read_cycles got=%0d want=%0d", read_cnt, MW + 1);
    end
    $display("test_jr: pc=%0d done_cycle=%0d read_cycles=%0d", pc, done_cyc, read_cnt);
  endtask

  task automatic test_jal(input logic with_stall);
    int done_cyc = -1, st1 = 0, st4 = 0, extra;
    extra = with_stall ? 4 : 0;
    for (int i = 0; i < 16; i++) init_regs[i] = 32'd50 + 32'(i);
    init_regs[6] = 32'd27;
    mem[13] = {OP_JAL, 4'd6, 23'd0};
    mem[27] = {5'b00001, 4'd0, 23'd0};
    restart(32'd13);
    for (int c = 0; c < 11 + 2 * MW + extra; c++) begin
      @(negedge clock);
      stall = 1'b0;
      if (with_stall) begin
        if (model_front() == 2 && st1 < 2) begin stall = 1'b1; st1++; end
        if (model_front() == 5 && st4 < 2) begin stall = 1'b1; st4++; end
      end
      run = (c == 0) || (c == 5 + MW + extra);
      #1;
      ev = exp_vec(stall);
      checks++;
      if (act_vec !== ev) begin
        failures++;
        $display("FAIL jal_vec stall=%0d cyc=%0d got=%b want=%b", with_stall, c, act_vec, ev);
      end
      if (done && done_cyc < 0) done_cyc = c;
      if (c == 6 + MW + extra) begin
        checks++;
        if (pc !== 32'd27 || regs[15] !== 32'd14) begin
          failures++;
          $display("FAIL jal_arch pc=%0d r15=%0d want pc=27 r15=14", pc, regs[15]);
        end
      end
      @(posedge clock);
      model_edge(stall, run);
    end
    checks++;
    if (done_cyc !== 5 + MW + extra) begin
      failures++;
      $display("FAIL jal_latency got=%0d want=%0d", done_cyc, 5 + MW + extra);
    end
    $display("test_jal: stall=%0d done_cycle=%0d r15=%0d", with_stall, done_cyc, regs[15]);
  endtask

  task automatic test_illegal();
    int ill_cyc = -1;
    for (int i = 0; i < 16; i++) init_regs[i] = 32'd50 + 32'(i);
    init_regs[6]  = 32'd27;
    init_regs[15] = 32'd77;
    mem[13] = {5'b00000, 4'd6, 23'd0};
    mem[14] = {OP_JR, 4'd6, 23'd0};
    restart(32'd13);
    for (int c = 0; c < 7 + MW; c++) begin
      @(negedge clock);
      stall = 1'b0;
      run   = (c == 0) || (c == 4 + MW);
      #1;
      ev = exp_vec(stall);
      checks++;
      if (act_vec !== ev) begin
        failures++;
        $display("FAIL illegal_vec cyc=%0d got=%b want=%b", c, act_vec, ev);
      end
      if (illegal && ill_cyc < 0) ill_cyc = c;
      if (c == 5 + MW) begin
        checks++;
        if (pc !== 32'd14 || regs[15] !== 32'd77 || regs[6] !== 32'd27) begin
          failures++;
          $display("FAIL illegal_arch pc=%0d r15=%0d r6=%0d want 14/77/27", pc, regs[15], regs[6]);
        end
      end
      @(posedge clock);
      model_edge(stall, run);
    end
    checks++;
    if (ill_cyc !== 4 + MW) begin
      failures++;
      $display("FAIL illegal_cycle got=%0d want=%0d", ill_cyc, 4 + MW);
    end
    $display("test_illegal: illegal_cycle=%0d pc=%0d", ill_cyc, pc);
  endtask

  task automatic test_clear_mid();
    logic hit = 1'b0;
    for (int i = 0; i < 16; i++) init_regs[i] = 32'd50 + 32'(i);
    init_regs[6]  = 32'd27;
    init_regs[7]  = 32'd40;
    init_regs[15] = 32'd99;
    mem[13] = {OP_JAL, 4'd6, 23'd0};
    mem[14] = {OP_JR, 4'd7, 23'd0};
    restart(32'd13);
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clock);
      stall = 1'b0;
      run   = (c == 0);
      #1;
      ev = exp_vec(stall);
      checks++;
      if (act_vec !== ev) begin
        failures++;
        $display("FAIL clear_pre_vec cyc=%0d got=%b want=%b", c, act_vec, ev);
      end
      if (model_front() == 3) hit = 1'b1;
      else begin
        @(posedge clock);
        model_edge(stall, run);
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL clear_reach_t2 got=timeout want=T2");
    end
    clear = 1'b0;
    #1;
    checks++;
    if (act_vec !== 18'd0) begin
      failures++;
      $display("FAIL clear_async got=%b want=%b", act_vec, 18'd0);
    end
    model_clear();
    @(posedge clock);
    #1;
    checks++;
    if (act_vec !== 18'd0 || regs[15] !== 32'd99 || pc !== 32'd14) begin
      failures++;
      $display("FAIL clear_hold vec=%b r15=%0d pc=%0d want 0/99/14", act_vec, regs[15], pc);
    end
    @(negedge clock);
    clear = 1'b1;
    for (int c = 0; c < 6 + MW; c++) begin
      @(negedge clock);
      stall = 1'b0;
      run   = (c == 0);
      #1;
      ev = exp_vec(stall);
      checks++;
      if (act_vec !== ev) begin
        failures++;
        $display("FAIL clear_post_vec cyc=%0d got=%b want=%b", c, act_vec, ev);
      end
      @(posedge clock);
      model_edge(stall, run);
    end
    #1;
    checks++;
    if (pc !== 32'd40 || regs[15] !== 32'd99) begin
      failures++;
      $display("FAIL clear_refetch pc=%0d r15=%0d want 40/99", pc, regs[15]);
    end
    $display("test_clear_mid: pc=%0d r15=%0d", pc, regs[15]);
  endtask

  task automatic test_back_to_back_random();
    logic       arch_due = 1'b0;
    logic [4:0] op;
    int         start_ret;
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = OP_JR;
        4, 5, 6, 7: op = OP_JAL;
        default: begin
          op = 5'($urandom_range(0, 31));
          while (op == OP_JR || op == OP_JAL) op = 5'($urandom_range(0, 31));
        end
      endcase
      mem[i] = {op, 4'($urandom_range(0, 15)), 23'($urandom)};
    end
    for (int i = 0; i < 16; i++) init_regs[i] = 32'($urandom_range(0, 63));
    restart(32'($urandom_range(0, 63)));
    start_ret = n_retired;
    for (int c = 0; c < 500; c++) begin
      @(negedge clock);
      stall = ($urandom_range(0, 4) == 0);
      run   = ($urandom_range(0, 9) != 0);
      #1;
      ev = exp_vec(stall);
      checks++;
      if (act_vec !== ev) begin
        failures++;
        $display("FAIL rand_vec cyc=%0d got=%b want=%b", c, act_vec, ev);
      end
      checks++;
      if ($countones({PCout, Rout, MDRout}) > 1) begin
        failures++;
        $display("FAIL rand_bus_drivers cyc=%0d got=%b want<=1 hot", c, {PCout, Rout, MDRout});
      end
      if (arch_due) begin
        checks++;
        if (pc !== exp_pc || regs[15] !== exp_regs[15]) begin
          failures++;
          $display("FAIL rand_arch cyc=%0d pc=%0d r15=%0d want pc=%0d r15=%0d",
                   c, pc, regs[15], exp_pc, exp_regs[15]);
        end
        $display("retire cyc=%0d pc=%0d r15=%0d", c, pc, regs[15]);
      end
      @(posedge clock);
      model_edge(stall, run);
      arch_due = m_retired;
    end
    checks++;
    if (n_retired - start_ret < 10) begin
      failures++;
      $display("FAIL rand_progress got=%0d want>=10", n_retired - start_ret);
    end
    $display("test_back_to_back_random: retired=%0d", n_retired - start_ret);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_retired = 0;
    m_retired = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    test_reset();
    test_jr();
    test_jal(1'b0);
    test_jal(1'b1);
    test_illegal();
    test_clear_mid();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
